// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Counter must be able to represent MAX_BURST itself, hence the extra bit.
  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  function automatic int rr_index(input int base, input int step, input int num_req);
    return (base + step) % num_req;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Round-robin selector: first requester after last_grant, wrapping at NUM_REQ.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  // Scan from the farthest candidate back to the nearest so the nearest one wins.
  always_comb begin
    winner = {ID_W{1'b0}};
    found  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      winner = req_mask[ID_W'(rr_index(int'(last_grant), k, NUM_REQ))]
             ? ID_W'(rr_index(int'(last_grant), k, NUM_REQ)) : winner;
      found  = req_mask[ID_W'(rr_index(int'(last_grant), k, NUM_REQ))] | found;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                         wclk,
  input  logic                         wrst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wFull,
  input  logic                         wHalfFull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wData,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam int                BEAT_W    = beat_width(MAX_BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   RST_LAST  = ID_W'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;

  logic [NUM_REQ-1:0]   elig_s;
  logic [ID_W-1:0]      pick_id_s;
  logic                 pick_found_s;
  logic                 owner_valid_s;
  logic                 owner_last_s;
  logic                 xfer_s;
  logic                 burst_done_s;
  logic [DATA_SIZE-1:0] words_s [NUM_REQ];

  // Half-full throttle leaves only the producer-0 drain lane eligible for new grants.
  assign elig_s = wHalfFull ? {{(NUM_REQ-1){1'b0}}, req_valid[0]} : req_valid;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_mask   (elig_s),
    .last_grant (last_grant_q),
    .winner     (pick_id_s),
    .found      (pick_found_s)
  );

  assign burst_done_s = owner_last_s | (beat_q == LAST_BEAT);

  // State, owner and beat-count registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q      <= IDLE;
      grant_q      <= {ID_W{1'b0}};
      last_grant_q <= RST_LAST;
      beat_q       <= {BEAT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

  // Next-state logic: grant in IDLE, count beats and detect burst end in BURST.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: begin
        if (!wFull && pick_found_s) begin
          state_d = BURST;
          grant_d = pick_id_s;
          beat_d  = {BEAT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (xfer_s) begin
          beat_d = beat_q + BEAT_W'(1);
          if (burst_done_s) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port outputs; forced quiet while reset is asserted so an abandoned burst never writes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words_s[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
    owner_valid_s = req_valid[grant_q];
    owner_last_s  = req_last[grant_q];
    req_ready     = {NUM_REQ{1'b0}};
    winc          = 1'b0;
    wData         = {DATA_SIZE{1'b0}};
    xfer_s        = 1'b0;
    if ((state_q == BURST) && !wrst && !wFull) begin
      req_ready[grant_q] = 1'b1;
      xfer_s             = owner_valid_s;
      winc               = owner_valid_s;
      wData              = owner_valid_s ? words_s[grant_q] : {DATA_SIZE{1'b0}};
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign busy     = (state_q == BURST);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized checks of fifo_write_arbiter against a cycle-level behavioural model.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 8;

  logic           wclk      = 1'b0;
  logic           wrst      = 1'b1;
  logic [NR-1:0]  req_valid = 4'b0000;
  logic [NR-1:0]  req_last  = 4'b0000;
  logic           wFull     = 1'b0;
  logic           wHalfFull = 1'b0;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           winc, busy;
  logic [DW-1:0]  wData;
  logic [1:0]     grant_id;

  int vectors = 0;
  int miscompares = 0;
  int seq [NR];
  logic [DW-1:0] wlog [$];

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wFull(wFull), .wHalfFull(wHalfFull),
    .winc(winc), .wData(wData), .grant_id(grant_id), .busy(busy)
  );

  // Producer p emits words tagged with its index in the top two bits and a running count below.
  function automatic logic [DW-1:0] word_of(input int p, input int s);
    return 8'(p * 64 + s % 64);
  endfunction

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i, seq[i]);
  end

  always @(posedge wclk) begin
    for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) seq[i] <= seq[i] + 1;
  end

  always @(posedge wclk) if (winc === 1'b1) wlog.push_back(wData);

  // Reference model: owner, beats done, last winner.
  logic       m_busy  = 1'b0;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_last  = 2'd3;
  int         m_cnt   = 0;
  int         m_pick;
  logic       exp_winc;
  logic [7:0] exp_data;
  logic [3:0] exp_ready;
  logic [15:0] act_v, exp_v;

  function automatic int rr_pick(input logic [1:0] last, input logic [3:0] v, input logic hf);
    for (int k = 1; k <= NR; k++) begin
      logic [1:0] idx;
      idx = 2'((int'(last) + k) % NR);
      if (v[idx] && (!hf || idx == 2'd0)) return int'(idx);
    end
    return -1;
  endfunction

  always_comb begin
    m_pick    = rr_pick(m_last, req_valid, wHalfFull);
    exp_winc  = m_busy && req_valid[m_owner] && !wFull && !wrst;
    exp_ready = (m_busy && !wFull && !wrst) ? (4'b0001 << m_owner) : 4'b0000;
    exp_data  = exp_winc ? word_of(int'(m_owner), seq[m_owner]) : 8'h00;
    exp_v     = {m_busy, exp_winc, exp_data, exp_ready, m_busy ? m_owner : 2'd0};
    act_v     = {busy, winc, wData, req_ready, m_busy ? grant_id : 2'd0};
  end

  always @(posedge wclk) begin
    if (wrst) begin
      m_busy <= 1'b0; m_owner <= 2'd0; m_cnt <= 0; m_last <= 2'd3;
    end else if (!m_busy) begin
      if (!wFull && m_pick >= 0) begin
        m_busy <= 1'b1; m_owner <= 2'(m_pick); m_cnt <= 0;
      end
    end else if (exp_winc) begin
      m_cnt <= m_cnt + 1;
      if (req_last[m_owner] || m_cnt + 1 == MB) begin
        m_busy <= 1'b0; m_last <= m_owner;
      end
    end
  end

  task automatic do_reset();
    @(negedge wclk);
    wrst = 1'b1; req_valid = 4'b0000; req_last = 4'b0000; wFull = 1'b0; wHalfFull = 1'b0;
    @(negedge wclk);
    wrst = 1'b0;
    wlog.delete();
  endtask

  task automatic test_reset();
    @(negedge wclk);
    wrst = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; wFull = 1'b0; wHalfFull = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk); #1; vectors++;
      if ({busy, winc, wData, req_ready, grant_id} !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset cyc%0d got %h want 0000", c, {busy, winc, wData, req_ready, grant_id});
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_last = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk); req_valid = 4'b1111; #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL rr cyc%0d got %h want %h", c, act_v, exp_v); end
    end
    @(negedge wclk); req_valid = 4'b0000; vectors++;
    if (wlog.size() != 5) begin miscompares++; $display("FAIL rr_count got %0d want 5", wlog.size()); end
    for (int j = 0; j < 5 && j < wlog.size(); j++) begin
      vectors++;
      if (wlog[j][7:6] !== 2'(j % 4)) begin
        miscompares++; $display("FAIL rr_order[%0d] got %0d want %0d", j, wlog[j][7:6], j % 4);
      end
    end
  endtask

  task automatic test_max_burst();
    int s0;
    do_reset();
    s0 = seq[2];
    for (int c = 0; c < 30; c++) begin
      @(negedge wclk); req_valid = (wlog.size() < 12) ? 4'b0100 : 4'b0000; #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL burst cyc%0d got %h want %h", c, act_v, exp_v); end
    end
    vectors++;
    if (wlog.size() != 12) begin miscompares++; $display("FAIL burst_count got %0d want 12", wlog.size()); end
    for (int j = 0; j < wlog.size(); j++) begin
      vectors++;
      if (wlog[j] !== word_of(2, s0 + j)) begin
        miscompares++; $display("FAIL burst_data[%0d] got %h want %h", j, wlog[j], word_of(2, s0 + j));
      end
    end
  endtask

  task automatic test_full_stall();
    int s0, fc;
    do_reset();
    s0 = seq[1]; fc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wclk);
      if (wlog.size() == 2 && fc < 3) begin wFull = 1'b1; fc++; end else wFull = 1'b0;
      req_valid = (wlog.size() < 6) ? 4'b0010 : 4'b0000;
      req_last  = (seq[1] - s0 == 5) ? 4'b0010 : 4'b0000;
      #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL stall cyc%0d got %h want %h", c, act_v, exp_v); end
      if (wFull) begin
        vectors++;
        if ({winc, req_ready[1]} !== 2'b00) begin
          miscompares++; $display("FAIL stall_gate cyc%0d got %b want 00", c, {winc, req_ready[1]});
        end
      end
    end
    vectors++;
    if (wlog.size() != 6) begin miscompares++; $display("FAIL stall_count got %0d want 6", wlog.size()); end
    for (int j = 0; j < wlog.size(); j++) begin
      vectors++;
      if (wlog[j] !== word_of(1, s0 + j)) begin
        miscompares++; $display("FAIL stall_data[%0d] got %h want %h", j, wlog[j], word_of(1, s0 + j));
      end
    end
  endtask

  task automatic test_half_full();
    do_reset();
    req_last = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      @(negedge wclk);
      wHalfFull = (c < 5);
      req_valid = (c < 4) ? 4'b1110 : 4'b1111;
      #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL halffull cyc%0d got %h want %h", c, act_v, exp_v); end
    end
    vectors++;
    if (wlog.size() != 3) begin miscompares++; $display("FAIL hf_count got %0d want 3", wlog.size()); end
    for (int j = 0; j < 3 && j < wlog.size(); j++) begin
      vectors++;
      if (wlog[j][7:6] !== 2'(j)) begin
        miscompares++; $display("FAIL hf_order[%0d] got %0d want %0d", j, wlog[j][7:6], j);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int phase;
    do_reset();
    phase = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge wclk);
      if (phase == 0) begin
        req_valid = 4'b1000;
        if (wlog.size() == 2) begin wrst = 1'b1; phase = 1; end
      end else if (phase == 1) begin
        wrst = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; phase = 2;
        #1; vectors++;
        if ({busy, winc, wData, req_ready, grant_id} !== 16'h0000) begin
          miscompares++;
          $display("FAIL rst_mid_vals got %h want 0000", {busy, winc, wData, req_ready, grant_id});
        end
      end else begin
        phase = 3;
      end
      #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL rstmid cyc%0d got %h want %h", c, act_v, exp_v); end
    end
    vectors++;
    if (wlog.size() < 3 || wlog[2][7:6] !== 2'd0) begin
      miscompares++; $display("FAIL rst_mid_regrant got size %0d want third write from producer 0", wlog.size());
    end
  endtask

  task automatic test_drop_valid();
    int s0, dc;
    do_reset();
    s0 = seq[0]; dc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wclk);
      if (wlog.size() == 2 && dc < 5) begin req_valid = 4'b1110; dc++; end else req_valid = 4'b1111;
      req_last = (seq[0] - s0 == 3) ? 4'b1111 : 4'b1110;
      #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL drop cyc%0d got %h want %h", c, act_v, exp_v); end
    end
    vectors++;
    if (wlog.size() < 5) begin miscompares++; $display("FAIL drop_count got %0d want >=5", wlog.size()); end
    for (int j = 0; j < 4 && j < wlog.size(); j++) begin
      vectors++;
      if (wlog[j] !== word_of(0, s0 + j)) begin
        miscompares++; $display("FAIL drop_data[%0d] got %h want %h", j, wlog[j], word_of(0, s0 + j));
      end
    end
    if (wlog.size() >= 5) begin
      vectors++;
      if (wlog[4][7:6] !== 2'd1) begin
        miscompares++; $display("FAIL drop_next got %0d want 1", wlog[4][7:6]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge wclk);
      wrst      = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom);
      req_last  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      wFull     = ($urandom_range(0, 4) == 0);
      wHalfFull = ($urandom_range(0, 3) == 0);
      #1; vectors++;
      if (act_v !== exp_v) begin miscompares++; $display("FAIL random cyc%0d got %h want %h", c, act_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_half_full();
    test_reset_mid_burst();
    test_drop_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ producers in the write clock domain. Grants are round-robin and burst-locked: a granted producer keeps the port until its last beat or MAX_BURST beats. The block drives winc/wData straight into the FIFO write port and uses wFull/wHalfFull for flow control and admission throttling.

## Interface
- DATA_SIZE, 8, width of one FIFO word
- NUM_REQ, 4, number of producers (2..16)
- MAX_BURST, 8, maximum beats per grant (1..256)
- ID_W, $clog2(NUM_REQ), derived, grant index width
- wclk  in  1  write-domain clock; only clock of the block
- wrst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NUM_REQ  producer i holds a word
- req_data  in  NUM_REQ*DATA_SIZE  producer i word at bits [i*DATA_SIZE +: DATA_SIZE]
- req_last  in  NUM_REQ  producer i word is final beat of its burst
- req_ready  out  NUM_REQ  word of producer i accepted this cycle when valid&ready
- wFull  in  1  FIFO full flag
- wHalfFull  in  1  FIFO half-full flag
- winc  out  1  FIFO write strobe
- wData  out  DATA_SIZE  FIFO write data
- grant_id  out  ID_W  index of current owner (valid when busy)
- busy  out  1  burst in progress

## Operation
- FSM states: IDLE, BURST.
- IDLE: if wFull=0 and an eligible req_valid exists, pick winner round-robin starting at last_grant+1 (wrapping at NUM_REQ); register grant_id, clear beat_cnt, go BURST. No transfer in IDLE.
- Eligibility: when wHalfFull=1, only producer 0 eligible (priority drain lane); when wHalfFull=0, all eligible. Throttle applies only at grant time, never cuts an active burst.
- BURST: req_ready[grant_id] = ~wFull; all other req_ready = 0. winc = req_valid[grant_id] & ~wFull; wData = req_data[grant_id] (0 when winc=0).
- Each transfer increments beat_cnt (width $clog2(MAX_BURST)+1, no wrap).
- Burst ends on transfer with req_last=1 or with beat_cnt reaching MAX_BURST-1 (i.e. MAX_BURST-th beat); next state IDLE, last_grant <= grant_id.
- Owner dropping req_valid mid-burst: stall in BURST, hold grant, no timeout.
- wFull=1 in BURST: stall, no winc, beat_cnt holds.
- Reset values: state IDLE, last_grant = NUM_REQ-1 (producer 0 wins first), beat_cnt 0, grant_id 0, busy 0, req_ready 0, winc 0, wData 0.
- Reset mid-burst: burst abandoned, no winc in the reset cycle or after until a fresh grant; partial burst stays in FIFO.

## Timing
- Grant latency: valid sampled in IDLE at edge N; grant_id/busy valid after edge N; first winc possible in cycle N+1.
- Throughput in BURST: one word per cycle while valid & ~wFull.
- One IDLE bubble cycle between consecutive bursts (including same producer re-winning).
- req_ready, winc, wData combinational from registered grant and wFull/req_valid; no combinational path from req_valid to grant_id.
- wFull/wHalfFull are synchronous to wclk; no synchronizers inside.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, BURST), ID_W/beat-count width helper functions.
- One sub-module: rr_priority_pick (combinational, NUM_REQ-wide request mask + last_grant in, winner index + found out); FSM, counters, muxing in top.

## Test plan
- Reset then req_valid=4'b1111, all req_last=1 on first beat, wFull=0 -> winc once per grant, grant order 0,1,2,3,0 with one bubble between each.
- Producer 2 alone, 12 beats no req_last, MAX_BURST=8 -> 8 winc, IDLE bubble, regrant to 2, remaining 4 beats; wData matches sent sequence.
- wFull asserted for 3 cycles mid-burst of producer 1 -> winc=0 and req_ready[1]=0 those cycles, no data lost/duplicated, burst resumes.
- wHalfFull=1 with req_valid=4'b1110 -> no grant; raise req_valid[0] -> producer 0 granted next edge; drop wHalfFull -> round-robin resumes from 1.
- wrst pulsed on beat 3 of producer 3 burst -> all outputs at reset values next cycle, next grant goes to producer 0.
- Owner drops req_valid for 5 cycles mid-burst while others valid -> grant held, no winc, beat_cnt unchanged, completes on req_last.
